bcd_scan_display: RTL and testbench

Time-multiplexed 3-digit seven-segment driver sitting directly downstream of `multi_decade_counter`. It consumes the `hundreds`/`tens`/`ones` BCD digits and `done`, and scans them onto a common-anode display. Each frame uses a tear-free snapshot of the inputs, with optional leading-zero blanking. `done` is shown on the ones-digit decimal point.

---
 rtl/seven_seg_pkg.sv | 34 +++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/bcd_scan_display.sv | 120 ++++++++++++
 tb/tb_bcd_scan_display.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment codes, scan states and snapshot type for the seven-segment display blocks
package seven_seg_pkg;

   // Active-low segment codes {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [2:0] AN_OFF = 3'b111;

   typedef enum logic [1:0] {
      D0 = 2'd0,
      D1 = 2'd1,
      D2 = 2'd2
   } scan_state_e;

   typedef struct packed {
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
      logic       done;
      logic       blank_lz;
   } snap_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to active-low seven-segment decoder, dash for 10..15
module bcd_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - 3-digit multiplexed seven-segment driver with per-frame snapshot
// and leading-zero blanking; done is shown on the ones decimal point.
module bcd_scan_display
   import seven_seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned CNT_W       = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   input  logic [3:0] hundreds,
   input  logic       done,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic       dp,
   output logic [2:0] an
);

   localparam logic [CNT_W-1:0] RCNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   scan_state_e      idx_q, idx_d;
   snap_t            snap_q, snap_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic             dp_q, dp_d;
   logic             tick;
   logic [3:0]       digit;
   logic [6:0]       code;
   logic             blank_h, blank_t;

   // >= rather than == so an upset counter value wraps instead of running away
   assign tick = (rcnt_q >= RCNT_MAX);

   always_comb begin
      rcnt_d = tick ? '0 : rcnt_q + CNT_W'(1);
      idx_d  = idx_q;
      if (tick) begin
         case (idx_q)
            D0:      idx_d = D1;
            D1:      idx_d = D2;
            default: idx_d = D0;
         endcase
      end
      snap_d = snap_q;
      if (tick && idx_q == D2) begin
         snap_d.h        = hundreds;
         snap_d.t        = tens;
         snap_d.o        = ones;
         snap_d.done     = done;
         snap_d.blank_lz = blank_lz;
      end
   end

   always_comb begin
      digit = 4'd0;
      case (idx_q)
         D0:      digit = snap_q.o;
         D1:      digit = snap_q.t;
         D2:      digit = snap_q.h;
         default: digit = 4'd0;
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd_i (digit),
      .seg_o (code)
   );

   // Invalid digits (10..15) are nonzero, so they stop blanking to their right
   assign blank_h = snap_q.blank_lz && (snap_q.h == 4'd0);
   assign blank_t = blank_h && (snap_q.t == 4'd0);

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      case (idx_q)
         D0: begin
            an_d  = 3'b110;
            seg_d = code;
            dp_d  = ~snap_q.done;
         end
         D1: if (!blank_t) begin
            an_d  = 3'b101;
            seg_d = code;
         end
         D2: if (!blank_h) begin
            an_d  = 3'b011;
            seg_d = code;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt_q <= '0;
         idx_q  <= D0;
         snap_q <= '0;
         an_q   <= AN_OFF;
         seg_q  <= SEG_BLANK;
         dp_q   <= 1'b1;
      end else begin
         rcnt_q <= rcnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display against a frame-level model
module tb_bcd_scan_display;

   localparam int RD    = 4;
   localparam int FRAME = 3 * RD;
   localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ones, tens, hundreds;
   logic       done, blank_lz;
   logic [6:0] seg;
   logic       dp;
   logic [2:0] an;

   int checks = 0;
   int errors = 0;
   int edges  = 0;

   // Model of the displayed frame: the inputs captured at the last frame boundary
   logic [3:0] m_h = 4'd0, m_t = 4'd0, m_o = 4'd0;
   logic       m_done = 1'b0, m_blz = 1'b0;

   bcd_scan_display #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .ones     (ones),
      .tens     (tens),
      .hundreds (hundreds),
      .done     (done),
      .blank_lz (blank_lz),
      .seg      (seg),
      .dp       (dp),
      .an       (an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_ref(input logic [3:0] v);
      return (v > 4'd9) ? 7'h3F : SEG_TAB[v];
   endfunction

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle(input string tag);
      logic [2:0] ea;
      logic [6:0] es;
      logic       ed;
      logic       blank;
      int         slot;
      @(posedge clk);
      if (reset) begin
         edges = 0;
         m_h = 0; m_t = 0; m_o = 0; m_done = 0; m_blz = 0;
         ea = 3'b111; es = 7'h7F; ed = 1'b1;
      end else begin
         edges++;
         slot = ((edges - 1) / RD) % 3;
         ea = 3'b111; es = 7'h7F; ed = 1'b1;
         if (slot == 0) begin
            ea = 3'b110; es = seg_ref(m_o); ed = ~m_done;
         end else if (slot == 1) begin
            blank = m_blz && m_h == 0 && m_t == 0;
            if (!blank) begin ea = 3'b101; es = seg_ref(m_t); end
         end else begin
            blank = m_blz && m_h == 0;
            if (!blank) begin ea = 3'b011; es = seg_ref(m_h); end
         end
         if (edges % FRAME == 0) begin
            m_h = hundreds; m_t = tens; m_o = ones; m_done = done; m_blz = blank_lz;
         end
      end
      #1;
      chk({tag, ".an"}, {4'd0, an}, {4'd0, ea});
      chk({tag, ".seg"}, seg, es);
      chk({tag, ".dp"}, {6'd0, dp}, {6'd0, ed});
   endtask

   task automatic set_in(input logic [3:0] h, t, o, input logic d, b);
      hundreds = h; tens = t; ones = o; done = d; blank_lz = b;
   endtask

   task automatic show(input logic [3:0] h, t, o, input logic d, b, input string tag);
      set_in(h, t, o, d, b);
      do cycle(tag); while (edges % FRAME != 0);
      repeat (FRAME) cycle(tag);
   endtask

   initial begin
      reset = 1'b1;
      set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      repeat (3) cycle("reset");
      chk("reset_an", {4'd0, an}, 7'h07);
      chk("reset_seg", seg, 7'h7F);
      reset = 1'b0;
      set_in(4'd3, 4'd2, 4'd1, 1'b0, 1'b0);
      cycle("release");
      chk("first_an", {4'd0, an}, 7'h06);
      chk("first_seg", seg, 7'h40);

      show(4'd3, 4'd2, 4'd1, 1'b0, 1'b0, "scan123");
      repeat (FRAME) cycle("scan123b");

      while (edges % FRAME != 5) cycle("tear_align");
      set_in(4'd9, 4'd8, 4'd7, 1'b0, 1'b0);
      cycle("tear");
      chk("tear_old_seg", seg, 7'h24);
      while (edges % FRAME != 0) cycle("tear_rest");
      cycle("tear_new");
      chk("tear_new_seg", seg, 7'h78);
      chk("tear_new_an", {4'd0, an}, 7'h06);
      repeat (FRAME - 1) cycle("tear_new");

      show(4'd0, 4'd0, 4'd7, 1'b0, 1'b1, "lz007");
      show(4'd0, 4'd7, 4'd0, 1'b0, 1'b1, "lz070");
      show(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "lz000");
      show(4'd0, 4'd12, 4'd5, 1'b0, 1'b1, "inv_t");
      show(4'd4, 4'd5, 4'd6, 1'b1, 1'b0, "done");
      show(4'd9, 4'd9, 4'd9, 1'b1, 1'b1, "term999");

      while (edges % FRAME != 9) cycle("mid_align");
      reset = 1'b1;
      cycle("mid_reset");
      chk("mid_reset_an", {4'd0, an}, 7'h07);
      reset = 1'b0;
      cycle("mid_release");
      chk("mid_release_seg", seg, 7'h40);
      chk("mid_release_dp", {6'd0, dp}, 7'h01);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0)
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0 && $urandom_range(0, 3) == 0)
            set_in(4'd0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 1'b0, 1'b1);
         reset = ($urandom_range(0, 59) == 0);
         cycle("random");
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
